// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: key input from the scan/debounce stage and the two BCD operands plus
// status toward downstream arithmetic/display. The slave modport is the entry controller.
interface keypad_entry_ctrl_if #(
    parameter int unsigned MAX_DIGITS = 4
);
    localparam int unsigned W = 4 * MAX_DIGITS;

    logic [3:0]   key_code;
    logic         key_down;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         operands_valid;
    logic         busy;
    logic         overflow;
    logic [3:0]   digit_count;
    logic         timeout;

    modport master (
        output key_code, key_down,
        input  operand_a, operand_b, operands_valid, busy, overflow, digit_count, timeout
    );

    modport slave (
        input  key_code, key_down,
        output operand_a, operand_b, operands_valid, busy, overflow, digit_count, timeout
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: edge-detects key presses and assembles two BCD operands.
// Define ENTRY_TIMEOUT_EN to abandon an entry after TIMEOUT_CYCLES idle cycles.
module keypad_entry_ctrl #(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 135_000_000
) (
    input  logic               clk,
    input  logic               n_reset,
    keypad_entry_ctrl_if.slave kp
);
    localparam int unsigned W = 4 * MAX_DIGITS;

    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    if (MAX_DIGITS < 1 || MAX_DIGITS > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("keypad_entry_ctrl: MAX_DIGITS must be 1..15 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY_A,
        S_ENTRY_B,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] op_a_q, op_a_d;
    logic [W-1:0] op_b_q, op_b_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         key_down_q;
    logic         press;
    logic         is_digit;
    logic         full;
`ifdef ENTRY_TIMEOUT_EN
    logic [31:0]  idle_cnt_q, idle_cnt_d;
    logic         timeout_q, timeout_d;
`endif

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] op, input logic [3:0] digit);
        return (op << 4) | W'(digit);
    endfunction

    assign press    = kp.key_down & ~key_down_q;
    assign is_digit = (kp.key_code <= 4'd9);
    assign full     = (cnt_q == 4'(MAX_DIGITS));

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        timeout_d  = 1'b0;
        idle_cnt_d = (press || state_q == S_IDLE || state_q == S_DONE) ? '0 : idle_cnt_q + 32'd1;
`endif
        if (press && kp.key_code == KEY_CLEAR) begin
            state_d = S_IDLE;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press && is_digit) begin
                        op_a_d  = W'(kp.key_code);
                        op_b_d  = '0;
                        cnt_d   = 4'd1;
                        ovf_d   = 1'b0;
                        state_d = S_ENTRY_A;
                    end
                end
                S_ENTRY_A: begin
                    if (press && is_digit) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            op_a_d = shift_in(op_a_q, kp.key_code);
                            cnt_d  = cnt_q + 4'd1;
                        end
                    end else if (press && kp.key_code == KEY_NEXT && cnt_q != 4'd0) begin
                        state_d = S_ENTRY_B;
                        cnt_d   = '0;
                    end
                end
                S_ENTRY_B: begin
                    if (press && is_digit) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            op_b_d = shift_in(op_b_q, kp.key_code);
                            cnt_d  = cnt_q + 4'd1;
                        end
                    end else if (press && kp.key_code == KEY_ENTER && cnt_q != 4'd0) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
`ifdef ENTRY_TIMEOUT_EN
        // Any press in the expiry cycle takes priority over abandoning the entry.
        if (!press && (state_q == S_ENTRY_A || state_q == S_ENTRY_B) &&
            idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_IDLE;
            op_a_d    = '0;
            op_b_d    = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            key_down_q <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            key_down_q <= kp.key_down;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign kp.operand_a      = op_a_q;
    assign kp.operand_b      = op_b_q;
    assign kp.operands_valid = valid_q;
    assign kp.busy           = busy_q;
    assign kp.overflow       = ovf_q;
    assign kp.digit_count    = cnt_q;
`ifdef ENTRY_TIMEOUT_EN
    assign kp.timeout        = timeout_q;
`else
    assign kp.timeout        = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with MAX_DIGITS=4; the timeout section runs only
// when ENTRY_TIMEOUT_EN is defined (TIMEOUT_CYCLES then set to 100).
module tb_keypad_entry_ctrl;
`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 100;
`else
    localparam int unsigned TO_CYCLES = 135_000_000;
`endif

    logic clk;
    logic n_reset;
    int   tests;
    int   failed;
    int   vcount;
    int   tcount;

    keypad_entry_ctrl_if #(.MAX_DIGITS(4)) kp();

    keypad_entry_ctrl #(
        .MAX_DIGITS    (4),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .kp     (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kp.operands_valid === 1'b1) vcount++;
        if (kp.timeout === 1'b1) tcount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the key for 'hold' cycles then releases for 3.
    task automatic press(input logic [3:0] k, input int unsigned hold);
        kp.key_code = k;
        kp.key_down = 1'b1;
        repeat (hold) @(negedge clk);
        kp.key_down = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        vcount      = 0;
        tcount      = 0;
        n_reset     = 1'b0;
        kp.key_code = 4'h0;
        kp.key_down = 1'b0;
        #12;
        check("rst_op_a", 32'(kp.operand_a), 32'h0);
        check("rst_op_b", 32'(kp.operand_b), 32'h0);
        check("rst_valid", 32'(kp.operands_valid), 32'h0);
        check("rst_busy", 32'(kp.busy), 32'h0);
        check("rst_ovf", 32'(kp.overflow), 32'h0);
        check("rst_cnt", 32'(kp.digit_count), 32'h0);
        check("rst_timeout", 32'(kp.timeout), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        // Normal entry 12 A 34 E
        vcount = 0;
        press(4'h1, 3);
        check("entry_a1", 32'(kp.operand_a), 32'h0001);
        check("entry_busy", 32'(kp.busy), 32'h1);
        press(4'h2, 3);
        check("entry_a12", 32'(kp.operand_a), 32'h0012);
        check("entry_cnt2", 32'(kp.digit_count), 32'h2);
        press(4'hA, 3);
        check("entry_next_cnt", 32'(kp.digit_count), 32'h0);
        press(4'h3, 3);
        press(4'h4, 3);
        check("entry_b34", 32'(kp.operand_b), 32'h0034);
        kp.key_code = 4'hE;
        kp.key_down = 1'b1;
        @(negedge clk);
        check("done_valid", 32'(kp.operands_valid), 32'h1);
        check("done_busy", 32'(kp.busy), 32'h1);
        check("done_op_a", 32'(kp.operand_a), 32'h0012);
        check("done_op_b", 32'(kp.operand_b), 32'h0034);
        @(negedge clk);
        check("post_valid", 32'(kp.operands_valid), 32'h0);
        check("post_busy", 32'(kp.busy), 32'h0);
        check("post_cnt", 32'(kp.digit_count), 32'h0);
        @(negedge clk);
        kp.key_down = 1'b0;
        repeat (3) @(negedge clk);
        check("entry_pulses", 32'(vcount), 32'd1);
        check("held_op_a", 32'(kp.operand_a), 32'h0012);

        // Overflow then clear
        press(4'h1, 3);
        check("ovf_b_cleared", 32'(kp.operand_b), 32'h0);
        press(4'h2, 3);
        press(4'h3, 3);
        press(4'h4, 3);
        check("ovf_pre", 32'(kp.overflow), 32'h0);
        press(4'h5, 3);
        check("ovf_op_a", 32'(kp.operand_a), 32'h1234);
        check("ovf_flag", 32'(kp.overflow), 32'h1);
        check("ovf_cnt", 32'(kp.digit_count), 32'h4);
        press(4'hD, 3);
        check("clr_op_a", 32'(kp.operand_a), 32'h0);
        check("clr_ovf", 32'(kp.overflow), 32'h0);
        check("clr_cnt", 32'(kp.digit_count), 32'h0);
        check("clr_busy", 32'(kp.busy), 32'h0);

        // Ignored keys in IDLE and ENTRY_A, and a long hold
        vcount = 0;
        press(4'hA, 3);
        press(4'hE, 3);
        press(4'hB, 3);
        check("idle_ign_busy", 32'(kp.busy), 32'h0);
        check("idle_ign_cnt", 32'(kp.digit_count), 32'h0);
        press(4'h7, 3);
        press(4'hE, 3);
        press(4'hC, 3);
        check("a_ign_busy", 32'(kp.busy), 32'h1);
        check("a_ign_cnt", 32'(kp.digit_count), 32'h1);
        press(4'h7, 50);
        check("hold_op_a", 32'(kp.operand_a), 32'h0077);
        check("hold_cnt", 32'(kp.digit_count), 32'h2);
        check("ign_pulses", 32'(vcount), 32'd0);
        press(4'hD, 3);

        // Empty-B guard
        vcount = 0;
        press(4'h5, 3);
        press(4'hA, 3);
        press(4'hE, 3);
        check("guard_none", 32'(vcount), 32'd0);
        check("guard_busy", 32'(kp.busy), 32'h1);
        press(4'hA, 3);
        check("guard_a_ign_cnt", 32'(kp.digit_count), 32'h0);
        press(4'h9, 3);
        press(4'hE, 3);
        check("guard_op_a", 32'(kp.operand_a), 32'h0005);
        check("guard_op_b", 32'(kp.operand_b), 32'h0009);
        check("guard_pulse", 32'(vcount), 32'd1);
        check("guard_busy_end", 32'(kp.busy), 32'h0);

        // Asynchronous reset in the middle of ENTRY_B
        vcount = 0;
        press(4'h6, 3);
        press(4'hA, 3);
        press(4'h3, 3);
        check("mid_b_op_b", 32'(kp.operand_b), 32'h0003);
        #2 n_reset = 1'b0;
        #1;
        check("arst_op_a", 32'(kp.operand_a), 32'h0);
        check("arst_op_b", 32'(kp.operand_b), 32'h0);
        check("arst_busy", 32'(kp.busy), 32'h0);
        check("arst_cnt", 32'(kp.digit_count), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        press(4'h4, 3);
        check("arst_idle_op_a", 32'(kp.operand_a), 32'h0004);
        check("arst_idle_cnt", 32'(kp.digit_count), 32'h1);
        check("arst_pulses", 32'(vcount), 32'd0);
        press(4'hD, 3);

`ifdef ENTRY_TIMEOUT_EN
        begin
            int waited;
            tcount = 0;
            press(4'h8, 3);
            waited = 0;
            while (kp.timeout !== 1'b1 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check("to_seen", 32'(kp.timeout), 32'h1);
            check("to_op_a", 32'(kp.operand_a), 32'h0);
            check("to_busy", 32'(kp.busy), 32'h0);
            @(negedge clk);
            check("to_pulse_once", 32'(tcount), 32'd1);
            // Second press lands exactly on the expiry edge.
            tcount = 0;
            kp.key_code = 4'h8;
            kp.key_down = 1'b1;
            repeat (3) @(negedge clk);
            kp.key_down = 1'b0;
            repeat (97) @(negedge clk);
            kp.key_code = 4'h2;
            kp.key_down = 1'b1;
            repeat (3) @(negedge clk);
            kp.key_down = 1'b0;
            repeat (40) @(negedge clk);
            check("to_race_none", 32'(tcount), 32'd0);
            check("to_race_op_a", 32'(kp.operand_a), 32'h0082);
            check("to_race_cnt", 32'(kp.digit_count), 32'h2);
            press(4'hD, 3);
        end
`else
        check("no_timeout", 32'(tcount), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
